// File: rtl/book_pkg.sv
// Shared types and default widths for the order-book read-modify-write controller.
package book_pkg;

    localparam int ADDR_WIDTH_DEF = 10;
    localparam int DATA_WIDTH_DEF = 32;

    typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;
    typedef logic [DATA_WIDTH_DEF-1:0] qty_t;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/book_rmw_alu.sv
// Combinational quantity update: base + signed delta.
// BOOK_RMW_SAT_EN selects clamping with flags; otherwise the sum wraps and flags stay low.
module book_rmw_alu
    import book_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0] base,
    input  logic [DATA_WIDTH-1:0] delta,
    output logic [DATA_WIDTH-1:0] qty,
    output logic                  underflow,
    output logic                  overflow
);

`ifdef BOOK_RMW_SAT_EN
    logic [DATA_WIDTH:0] sum;

    // A set top bit means negative for a negative delta, above max for a positive one.
    always_comb begin
        sum       = {1'b0, base} + {delta[DATA_WIDTH-1], delta};
        qty       = sum[DATA_WIDTH-1:0];
        underflow = 1'b0;
        overflow  = 1'b0;
        if (sum[DATA_WIDTH]) begin
            if (delta[DATA_WIDTH-1]) begin
                qty       = '0;
                underflow = 1'b1;
            end else begin
                qty       = '1;
                overflow  = 1'b1;
            end
        end
    end
`else
    // The low DATA_WIDTH bits of the extended sum equal a plain modular add.
    always_comb begin
        qty       = base + delta;
        underflow = 1'b0;
        overflow  = 1'b0;
    end
`endif

endmodule

// File: rtl/book_rmw_ctrl.sv
// Price-level book controller: read-modify-write over a dual-port BRAM (A reads, B writes),
// with full-book clear sequencing. Saturation is enabled by BOOK_RMW_SAT_EN.
//
// state | meaning
// CLEAR | write 0 to every address via port B, one per cycle; no ops accepted
// RUN   | accept queries and updates, one per cycle, queries first
// DRAIN | clear requested; wait for stage S1 to retire, then CLEAR
module book_rmw_ctrl
    import book_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [ADDR_WIDTH-1:0] upd_addr,
    input  logic [DATA_WIDTH-1:0] upd_delta,
    input  logic                  qry_valid,
    output logic                  qry_ready,
    input  logic [ADDR_WIDTH-1:0] qry_addr,
    output logic                  qry_rdata_valid,
    output logic [DATA_WIDTH-1:0] qry_rdata,
    output logic                  upd_done,
    output logic [DATA_WIDTH-1:0] upd_qty,
    output logic                  upd_underflow,
    output logic                  upd_overflow,
    input  logic                  clr_start,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] bram_addr_a,
    input  logic [DATA_WIDTH-1:0] bram_dout_a,
    output logic                  bram_we_b,
    output logic [ADDR_WIDTH-1:0] bram_addr_b,
    output logic [DATA_WIDTH-1:0] bram_din_b
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_upd_q, s1_upd_d;
    logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
    logic [DATA_WIDTH-1:0] s1_delta_q, s1_delta_d;
    logic                  lw_valid_q, lw_valid_d;
    logic [ADDR_WIDTH-1:0] lw_addr_q, lw_addr_d;
    logic [DATA_WIDTH-1:0] lw_data_q, lw_data_d;
    logic                  upd_done_q, upd_done_d;
    logic [DATA_WIDTH-1:0] upd_qty_q, upd_qty_d;
    logic                  upd_uf_q, upd_uf_d;
    logic                  upd_of_q, upd_of_d;

    logic                  run;
    logic                  qry_acc;
    logic                  upd_acc;
    logic                  s1_wr;
    logic                  clr_wr;
    logic [DATA_WIDTH-1:0] base;
    logic [DATA_WIDTH-1:0] alu_qty;
    logic                  alu_uf;
    logic                  alu_of;

    book_rmw_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .base      (base),
        .delta     (s1_delta_q),
        .qty       (alu_qty),
        .underflow (alu_uf),
        .overflow  (alu_of)
    );

    // A clear request drops both readies in the same cycle it is seen.
    always_comb begin
        run       = (state_q == RUN);
        qry_ready = run && !clr_start;
        upd_ready = run && !clr_start && !qry_valid;
        qry_acc   = qry_valid && qry_ready;
        upd_acc   = upd_valid && upd_ready;
        busy      = !run;

        bram_addr_a = '0;
        if (qry_acc) begin
            bram_addr_a = qry_addr;
        end else if (upd_acc) begin
            bram_addr_a = upd_addr;
        end

        // The BRAM read issued alongside last cycle's write returns stale data; bypass it.
        base = bram_dout_a;
        if (lw_valid_q && (lw_addr_q == s1_addr_q)) begin
            base = lw_data_q;
        end

        s1_wr  = s1_valid_q && s1_upd_q;
        clr_wr = (state_q == CLEAR) && rst_n;

        bram_we_b   = s1_wr || clr_wr;
        bram_addr_b = '0;
        bram_din_b  = '0;
        if (s1_wr) begin
            bram_addr_b = s1_addr_q;
            bram_din_b  = alu_qty;
        end else if (clr_wr) begin
            bram_addr_b = clr_cnt_q;
        end

        qry_rdata_valid = s1_valid_q && !s1_upd_q;
        qry_rdata       = qry_rdata_valid ? base : '0;
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                if (clr_cnt_q == '1) begin
                    state_d   = RUN;
                    clr_cnt_d = '0;
                end
            end
            RUN: begin
                if (clr_start) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!s1_valid_q) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_cnt_d = '0;
            end
        endcase

        s1_valid_d = qry_acc || upd_acc;
        s1_upd_d   = upd_acc;
        s1_addr_d  = bram_addr_a;
        s1_delta_d = upd_acc ? upd_delta : '0;

        lw_valid_d = bram_we_b;
        lw_addr_d  = bram_addr_b;
        lw_data_d  = bram_din_b;

        upd_done_d = s1_wr;
        upd_qty_d  = s1_wr ? alu_qty : upd_qty_q;
        upd_uf_d   = s1_wr && alu_uf;
        upd_of_d   = s1_wr && alu_of;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            clr_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_upd_q   <= 1'b0;
            s1_addr_q  <= '0;
            s1_delta_q <= '0;
            lw_valid_q <= 1'b0;
            lw_addr_q  <= '0;
            lw_data_q  <= '0;
            upd_done_q <= 1'b0;
            upd_qty_q  <= '0;
            upd_uf_q   <= 1'b0;
            upd_of_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_upd_q   <= s1_upd_d;
            s1_addr_q  <= s1_addr_d;
            s1_delta_q <= s1_delta_d;
            lw_valid_q <= lw_valid_d;
            lw_addr_q  <= lw_addr_d;
            lw_data_q  <= lw_data_d;
            upd_done_q <= upd_done_d;
            upd_qty_q  <= upd_qty_d;
            upd_uf_q   <= upd_uf_d;
            upd_of_q   <= upd_of_d;
        end
    end

    assign upd_done      = upd_done_q;
    assign upd_qty       = upd_qty_q;
    assign upd_underflow = upd_uf_q;
    assign upd_overflow  = upd_of_q;

endmodule

// File: tb/tb_book_rmw_ctrl.sv
// Self-checking bench for book_rmw_ctrl (ADDR_WIDTH=4, DATA_WIDTH=16) with a read-first BRAM model.
// Expected update and query results are queued at acceptance and compared when the DUT retires them.
module tb_book_rmw_ctrl;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk;
    logic          rst_n;
    logic          upd_valid;
    logic          upd_ready;
    logic [AW-1:0] upd_addr;
    logic [DW-1:0] upd_delta;
    logic          qry_valid;
    logic          qry_ready;
    logic [AW-1:0] qry_addr;
    logic          qry_rdata_valid;
    logic [DW-1:0] qry_rdata;
    logic          upd_done;
    logic [DW-1:0] upd_qty;
    logic          upd_underflow;
    logic          upd_overflow;
    logic          clr_start;
    logic          busy;
    logic [AW-1:0] bram_addr_a;
    logic [DW-1:0] bram_dout_a;
    logic          bram_we_b;
    logic [AW-1:0] bram_addr_b;
    logic [DW-1:0] bram_din_b;

    typedef struct {
        logic [DW-1:0] qty;
        logic          uf;
        logic          of;
    } upd_exp_t;

    upd_exp_t      upd_exp[$];
    logic [DW-1:0] qry_exp[$];
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] bram_mem [16] = '{default: 16'hBEEF};
    upd_exp_t      mon_e;
    logic [DW-1:0] mon_q;
    int            n_checks = 0;
    int            n_fail   = 0;

    book_rmw_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .upd_valid       (upd_valid),
        .upd_ready       (upd_ready),
        .upd_addr        (upd_addr),
        .upd_delta       (upd_delta),
        .qry_valid       (qry_valid),
        .qry_ready       (qry_ready),
        .qry_addr        (qry_addr),
        .qry_rdata_valid (qry_rdata_valid),
        .qry_rdata       (qry_rdata),
        .upd_done        (upd_done),
        .upd_qty         (upd_qty),
        .upd_underflow   (upd_underflow),
        .upd_overflow    (upd_overflow),
        .clr_start       (clr_start),
        .busy            (busy),
        .bram_addr_a     (bram_addr_a),
        .bram_dout_a     (bram_dout_a),
        .bram_we_b       (bram_we_b),
        .bram_addr_b     (bram_addr_b),
        .bram_din_b      (bram_din_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_we_b) bram_mem[bram_addr_b] <= bram_din_b;
        bram_dout_a <= bram_mem[bram_addr_a];
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (upd_done) begin
                n_checks++;
                if (upd_exp.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_upd_unexpected: upd_done with qty=%h, none expected", upd_qty);
                end else begin
                    mon_e = upd_exp.pop_front();
                    if ({upd_qty, upd_underflow, upd_overflow} !== {mon_e.qty, mon_e.uf, mon_e.of}) begin
                        n_fail++;
                        $display("FAIL sb_upd: got qty=%h uf=%b of=%b expected qty=%h uf=%b of=%b",
                                 upd_qty, upd_underflow, upd_overflow, mon_e.qty, mon_e.uf, mon_e.of);
                    end
                end
            end
            if (qry_rdata_valid) begin
                n_checks++;
                if (qry_exp.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_qry_unexpected: rdata=%h, none expected", qry_rdata);
                end else begin
                    mon_q = qry_exp.pop_front();
                    if (qry_rdata !== mon_q) begin
                        n_fail++;
                        $display("FAIL sb_qry: got rdata=%h expected %h", qry_rdata, mon_q);
                    end
                end
            end
        end
    end

    function automatic void model_update(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int       s;
        upd_exp_t e;
        s = int'(ref_mem[a]) + int'($signed(d));
`ifdef BOOK_RMW_SAT_EN
        if (s < 0) begin
            e.qty = '0; e.uf = 1'b1; e.of = 1'b0;
        end else if (s > 65535) begin
            e.qty = 16'hFFFF; e.uf = 1'b0; e.of = 1'b1;
        end else begin
            e.qty = DW'(s); e.uf = 1'b0; e.of = 1'b0;
        end
`else
        e.qty = DW'(s); e.uf = 1'b0; e.of = 1'b0;
`endif
        ref_mem[a] = e.qty;
        upd_exp.push_back(e);
    endfunction

    task automatic drive(input logic qv, input logic [AW-1:0] qa, input logic uv,
                         input logic [AW-1:0] ua, input logic [DW-1:0] ud, input logic cs,
                         output logic q_acc, output logic u_acc);
        @(negedge clk);
        qry_valid = qv;
        qry_addr  = qa;
        upd_valid = uv;
        upd_addr  = ua;
        upd_delta = ud;
        clr_start = cs;
        #1;
        q_acc = qv && qry_ready;
        u_acc = uv && upd_ready;
        if (q_acc) qry_exp.push_back(ref_mem[qa]);
        if (u_acc) model_update(ua, ud);
    endtask

    task automatic idle(input int n);
        logic qa, ua;
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, '0, 1'b0, qa, ua);
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({busy, upd_ready, qry_ready, bram_we_b, upd_done, qry_rdata_valid,
             upd_underflow, upd_overflow} !== 8'b1000_0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy=%b urdy=%b qrdy=%b we=%b done=%b qv=%b uf=%b of=%b expected 1,0,...",
                     busy, upd_ready, qry_ready, bram_we_b, upd_done, qry_rdata_valid, upd_underflow, upd_overflow);
        end
        n_checks++;
        if ({upd_qty, qry_rdata, bram_addr_b, bram_din_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: qty=%h rdata=%h addr_b=%h din_b=%h expected 0",
                     upd_qty, qry_rdata, bram_addr_b, bram_din_b);
        end
    endtask

    // Releases reset on a falling edge and checks the 16-cycle zeroing sweep.
    task automatic test_clear_sequence();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            n_checks++;
            if (busy !== 1'b1 || bram_we_b !== 1'b1 || bram_addr_b !== AW'(i) ||
                bram_din_b !== '0 || upd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_step%0d: busy=%b we=%b addr_b=%0d din_b=%h urdy=%b expected 1,1,%0d,0,0",
                         i, busy, bram_we_b, bram_addr_b, bram_din_b, upd_ready, i);
            end
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || upd_ready !== 1'b1 || qry_ready !== 1'b1 || bram_we_b !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_done: busy=%b urdy=%b qrdy=%b we=%b expected 0,1,1,0",
                     busy, upd_ready, qry_ready, bram_we_b);
        end
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    endtask

    task automatic test_accumulate();
        logic qa, ua;
        drive(1'b0, '0, 1'b1, 4'd3, 16'd100, 1'b0, qa, ua);
        drive(1'b0, '0, 1'b1, 4'd3, 16'd50, 1'b0, qa, ua);
        drive(1'b0, '0, 1'b1, 4'd3, -16'sd30, 1'b0, qa, ua);
        n_checks++;
        if (upd_done !== 1'b1 || upd_qty !== 16'd100) begin
            n_fail++;
            $display("FAIL acc_first: done=%b qty=%0d expected 1/100", upd_done, upd_qty);
        end
        drive(1'b1, 4'd3, 1'b0, '0, '0, 1'b0, qa, ua);
        n_checks++;
        if (upd_done !== 1'b1 || upd_qty !== 16'd150) begin
            n_fail++;
            $display("FAIL acc_second: done=%b qty=%0d expected 1/150", upd_done, upd_qty);
        end
        idle(1);
        n_checks++;
        if (upd_done !== 1'b1 || upd_qty !== 16'd120 || qry_rdata_valid !== 1'b1 || qry_rdata !== 16'd120) begin
            n_fail++;
            $display("FAIL acc_third_query: done=%b qty=%0d qv=%b rdata=%0d expected 1/120/1/120",
                     upd_done, upd_qty, qry_rdata_valid, qry_rdata);
        end
        idle(3);
    endtask

    task automatic test_saturation();
        logic qa, ua;
        drive(1'b0, '0, 1'b1, 4'd5, 16'd10, 1'b0, qa, ua);
        drive(1'b0, '0, 1'b1, 4'd5, -16'sd20, 1'b0, qa, ua);
        idle(2);
        n_checks++;
`ifdef BOOK_RMW_SAT_EN
        if (upd_done !== 1'b1 || upd_qty !== 16'h0000 || upd_underflow !== 1'b1 || upd_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_under: done=%b qty=%h uf=%b of=%b expected 1/0000/1/0",
                     upd_done, upd_qty, upd_underflow, upd_overflow);
        end
`else
        if (upd_done !== 1'b1 || upd_qty !== 16'hFFF6 || upd_underflow !== 1'b0 || upd_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_under: done=%b qty=%h uf=%b of=%b expected 1/fff6/0/0",
                     upd_done, upd_qty, upd_underflow, upd_overflow);
        end
`endif
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 4'd6, 16'h7FFF, 1'b0, qa, ua);
        drive(1'b1, 4'd6, 1'b0, '0, '0, 1'b0, qa, ua);
        idle(3);
    endtask

    task automatic test_priority();
        logic qa, ua;
        drive(1'b0, '0, 1'b1, 4'd9, 16'd40, 1'b0, qa, ua);
        drive(1'b1, 4'd9, 1'b1, 4'd9, 16'd2, 1'b0, qa, ua);
        n_checks++;
        if (qa !== 1'b1 || ua !== 1'b0 || upd_ready !== 1'b0 || qry_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_both: q_acc=%b u_acc=%b urdy=%b qrdy=%b expected 1,0,0,1",
                     qa, ua, upd_ready, qry_ready);
        end
        drive(1'b0, '0, 1'b1, 4'd9, 16'd2, 1'b0, qa, ua);
        n_checks++;
        if (ua !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_next: u_acc=%b expected 1", ua);
        end
        drive(1'b1, 4'd9, 1'b0, '0, '0, 1'b0, qa, ua);
        idle(3);
    endtask

    task automatic test_back_to_back();
        logic          qa, ua;
        logic          qv, uv;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int i = 0; i < 8; i++) drive(1'b0, '0, 1'b1, 4'd4, 16'd1, 1'b0, qa, ua);
        drive(1'b1, 4'd4, 1'b0, '0, '0, 1'b0, qa, ua);
        for (int i = 0; i < 60; i++) begin
            qv = ($urandom_range(0, 2) == 0);
            uv = ($urandom_range(0, 2) != 0);
            a  = AW'($urandom_range(10, 13));
            d  = DW'($urandom_range(0, 400)) - 16'd200;
            drive(qv, AW'($urandom_range(10, 13)), uv, a, d, 1'b0, qa, ua);
        end
        for (int i = 10; i < 14; i++) drive(1'b1, AW'(i), 1'b0, '0, '0, 1'b0, qa, ua);
        idle(3);
    endtask

    task automatic test_clear_cmd();
        logic qa, ua;
        int   cyc;
        drive(1'b0, '0, 1'b1, 4'd7, 16'd77, 1'b0, qa, ua);
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1, qa, ua);
        n_checks++;
        if (upd_ready !== 1'b0 || qry_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_ready_drop: urdy=%b qrdy=%b expected 0,0", upd_ready, qry_ready);
        end
        idle(1);
        n_checks++;
        if (busy !== 1'b1 || bram_we_b !== 1'b0 || upd_done !== 1'b1 || upd_qty !== 16'd77) begin
            n_fail++;
            $display("FAIL clr_drain: busy=%b we=%b done=%b qty=%0d expected 1,0,1,77",
                     busy, bram_we_b, upd_done, upd_qty);
        end
        idle(1);
        n_checks++;
        if (busy !== 1'b1 || bram_we_b !== 1'b1 || bram_addr_b !== 4'd0) begin
            n_fail++;
            $display("FAIL clr_enter: busy=%b we=%b addr_b=%0d expected 1,1,0", busy, bram_we_b, bram_addr_b);
        end
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        cyc = 0;
        while (busy && cyc < 40) begin
            drive(1'b0, '0, 1'b0, '0, '0, (cyc == 0), qa, ua);
            cyc++;
        end
        n_checks++;
        if (cyc !== 16) begin
            n_fail++;
            $display("FAIL clr_length: busy cleared after %0d cycles expected 16", cyc);
        end
        drive(1'b1, 4'd7, 1'b0, '0, '0, 1'b0, qa, ua);
        drive(1'b1, 4'd3, 1'b0, '0, '0, 1'b0, qa, ua);
        idle(3);
    endtask

    task automatic test_reset_mid_op();
        logic qa, ua;
        drive(1'b0, '0, 1'b1, 4'd2, 16'd55, 1'b0, qa, ua);
        @(negedge clk);
        upd_valid = 1'b0;
        rst_n     = 1'b0;
        upd_exp.delete();
        #1;
        n_checks++;
        if (upd_done !== 1'b0 || bram_we_b !== 1'b0 || busy !== 1'b1 || upd_qty !== '0) begin
            n_fail++;
            $display("FAIL rst_midop: done=%b we=%b busy=%b qty=%h expected 0,0,1,0",
                     upd_done, bram_we_b, busy, upd_qty);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (upd_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_midop_hold: done=%b expected 0", upd_done);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic qa, ua;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            n_checks++;
            if (bram_addr_b !== AW'(i) || bram_we_b !== 1'b1) begin
                n_fail++;
                $display("FAIL rst_clr_step%0d: addr_b=%0d we=%b expected %0d,1", i, bram_addr_b, bram_we_b, i);
            end
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, upd_ready, qry_ready, bram_we_b, upd_done, qry_rdata_valid} !== 6'b100000 ||
            {bram_addr_b, bram_din_b, bram_addr_a, upd_qty, qry_rdata} !== '0) begin
            n_fail++;
            $display("FAIL rst_clr_outputs: busy=%b urdy=%b qrdy=%b we=%b addr_b=%0d din_b=%h expected 1,0,0,0,0,0",
                     busy, upd_ready, qry_ready, bram_we_b, bram_addr_b, bram_din_b);
        end
        test_clear_sequence();
        drive(1'b1, 4'd2, 1'b0, '0, '0, 1'b0, qa, ua);
        drive(1'b1, 4'd14, 1'b0, '0, '0, 1'b0, qa, ua);
        idle(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        upd_valid = 1'b0;
        upd_addr  = '0;
        upd_delta = '0;
        qry_valid = 1'b0;
        qry_addr  = '0;
        clr_start = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;

        test_reset();
        test_clear_sequence();
        test_accumulate();
        test_saturation();
        test_priority();
        test_back_to_back();
        test_clear_cmd();
        test_reset_mid_op();
        test_reset_mid_clear();

        n_checks++;
        if (upd_exp.size() != 0 || qry_exp.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d updates and %0d queries still pending, expected 0",
                     upd_exp.size(), qry_exp.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
